// File: rtl/comparator_pipe.sv
// comparator_pipe: pipelined WIDTH-bit magnitude comparator, SEG bits per stage
// resolved MSB first, valid/ready on both sides with a single global advance.
// Optional feature: define COMPARATOR_PIPE_MINMAX_EN to add out_min/out_max,
// which needs the original operands carried to the last stage.

// Per-stage segment resolver: folds one SEG-bit slice into the carried verdict.
module comparator_pipe_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] seg_a,
  input  logic [SEG-1:0] seg_b,
  input  logic           dec,
  input  logic           gt,
  input  logic           lt,
  output logic           dec_n,
  output logic           gt_n,
  output logic           lt_n
);
  // First differing segment decides; later segments cannot override it.
  always_comb begin
    dec_n = dec;
    gt_n  = gt;
    lt_n  = lt;
    if (!dec) begin
      if (seg_a > seg_b) begin
        dec_n = 1'b1;
        gt_n  = 1'b1;
      end else if (seg_a < seg_b) begin
        dec_n = 1'b1;
        lt_n  = 1'b1;
      end
    end
  end
endmodule

module comparator_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_lt,
  output logic [TAG_W-1:0] out_tag
`ifdef COMPARATOR_PIPE_MINMAX_EN
  ,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max
`endif
);
  localparam int STAGES = WIDTH / SEG;

  logic             adv;
  logic [WIDTH-1:0] cap_a, cap_b;

  // Index 0 is the input side; index k+1 is the register of stage k.
  logic [STAGES:0]            vld_pipe, dec_pipe, gt_pipe, lt_pipe;
  logic [STAGES:0][TAG_W-1:0] tag_pipe;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign cap_a = in_a ^ (WIDTH'(in_signed) << (WIDTH - 1));
  assign cap_b = in_b ^ (WIDTH'(in_signed) << (WIDTH - 1));

  assign vld_pipe[0] = in_valid;
  assign dec_pipe[0] = 1'b0;
  assign gt_pipe[0]  = 1'b0;
  assign lt_pipe[0]  = 1'b0;
  assign tag_pipe[0] = in_tag;

`ifdef COMPARATOR_PIPE_MINMAX_EN
  logic [STAGES:0][WIDTH-1:0] ora_pipe, orb_pipe;
  assign ora_pipe[0] = in_a;
  assign orb_pipe[0] = in_b;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits still unresolved on entry to this stage.
    localparam int SW = WIDTH - k * SEG;

    logic [SW-1:0]    src_a, src_b;
    logic             dec_n, gt_n, lt_n;
    logic             vld_r, dec_r, gt_r, lt_r;
    logic [TAG_W-1:0] tag_r;

    if (k == 0) begin : g_first
      assign src_a = cap_a;
      assign src_b = cap_b;
    end else begin : g_next
      assign src_a = g_stg[k-1].g_carry.a_r;
      assign src_b = g_stg[k-1].g_carry.b_r;
    end

    comparator_pipe_seg #(.SEG(SEG)) u_seg (
      .seg_a (src_a[SW-1 -: SEG]),
      .seg_b (src_b[SW-1 -: SEG]),
      .dec   (dec_pipe[k]),
      .gt    (gt_pipe[k]),
      .lt    (lt_pipe[k]),
      .dec_n (dec_n),
      .gt_n  (gt_n),
      .lt_n  (lt_n)
    );

    // Control state of this stage: shifts on adv, bubbles travel as vld=0.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r <= 1'b0;
        dec_r <= 1'b0;
        gt_r  <= 1'b0;
        lt_r  <= 1'b0;
        tag_r <= '0;
      end else if (adv) begin
        vld_r <= vld_pipe[k];
        dec_r <= dec_n;
        gt_r  <= gt_n;
        lt_r  <= lt_n;
        tag_r <= tag_pipe[k];
      end
    end

    assign vld_pipe[k+1] = vld_r;
    assign dec_pipe[k+1] = dec_r;
    assign gt_pipe[k+1]  = gt_r;
    assign lt_pipe[k+1]  = lt_r;
    assign tag_pipe[k+1] = tag_r;

    // Only the not-yet-examined low bits travel on; the last stage keeps none.
    if (k < STAGES - 1) begin : g_carry
      logic [SW-SEG-1:0] a_r, b_r;
      // Remaining operand bits; pure data, qualified by vld downstream.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_r <= src_a[SW-SEG-1:0];
          b_r <= src_b[SW-SEG-1:0];
        end
      end
    end

`ifdef COMPARATOR_PIPE_MINMAX_EN
    logic [WIDTH-1:0] ora_r, orb_r;
    // Original operands ride along so min/max come out un-inverted.
    always_ff @(posedge clk) begin
      if (rst) begin
        ora_r <= '0;
        orb_r <= '0;
      end else if (adv) begin
        ora_r <= ora_pipe[k];
        orb_r <= orb_pipe[k];
      end
    end
    assign ora_pipe[k+1] = ora_r;
    assign orb_pipe[k+1] = orb_r;
`endif
  end

  assign out_valid = vld_pipe[STAGES];
  // Gate with valid so idle/reset shows all flags low; undecided means equal.
  assign out_eq    = out_valid && !dec_pipe[STAGES];
  assign out_gt    = out_valid && gt_pipe[STAGES];
  assign out_lt    = out_valid && lt_pipe[STAGES];
  assign out_tag   = tag_pipe[STAGES];

`ifdef COMPARATOR_PIPE_MINMAX_EN
  // Equal operands report A on both sides.
  assign out_min = gt_pipe[STAGES] ? orb_pipe[STAGES] : ora_pipe[STAGES];
  assign out_max = lt_pipe[STAGES] ? orb_pipe[STAGES] : ora_pipe[STAGES];
`endif
endmodule
